window_frame_packer: RTL
========================

# window_frame_packer

Serial-to-frame packer feeding the windowing stage. Accepts one 8-bit sample per cycle over a valid/ready stream and packs `size` consecutive samples into one `size*8`-bit frame whose layout matches the window multiplier's `input_function` bus. A frame buffer plus an output register let a new frame fill while the previous frame waits for the consumer.

## Interface
- `size`, 8: samples per frame; must be ≥2.
- `IDX_W`, 8: width of the frame index counter.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  8  input sample, unsigned.
- `s_valid`  in  1  `s_data` is valid this cycle.
- `s_ready`  out  1  packer accepts a sample this cycle.
- `frame_data`  out  `size*8`  packed frame; sample j sits at `frame_data[j*8 +: 8]`; j=0 is the oldest sample.
- `frame_valid`  out  1  `frame_data` and `frame_index` are valid.
- `frame_ready`  in  1  consumer takes the frame this cycle.
- `frame_index`  out  `IDX_W`  sequence number of the presented frame.

## Operation
- A sample is accepted when `s_valid && s_ready`. A frame is accepted when `frame_valid && frame_ready`.
- Fill counter `cnt` runs from 0 to size-1. An accepted sample is written to fill slot `cnt`.
- The state machine has two states:
  - FILL: `s_ready`=1.
  - HOLD: the fill buffer is complete but the output register is still occupied; `s_ready`=0.
- FILL, accepting a sample with `cnt` < size-1: `cnt` increments.
- FILL, accepting a sample with `cnt` = size-1 (last sample):
  - If the output register is free (`!frame_valid`, or a frame is accepted this same cycle), the completed buffer, including this sample, loads into the output register. `frame_valid` is set, `frame_index` is set to the running counter, the running counter increments, `cnt` goes to 0, and the state stays FILL.
  - Otherwise the state goes to HOLD and `cnt` stays at size-1.
- HOLD: on the first cycle the output register is free (`!frame_valid` or a frame is accepted), the buffer transfers as above, `cnt` goes to 0 and the state returns to FILL. `s_ready` goes high the following cycle.
- A frame is accepted with no new transfer: `frame_valid` clears.
- `frame_data` and `frame_index` are stable while `frame_valid && !frame_ready`.
- `frame_index` wraps modulo 2^`IDX_W`. The first frame after reset is index 0.
- No sample is ever dropped or duplicated. Backpressure reaches the source only through `s_ready`.

## Timing
- Reset, applied at any cycle including mid-frame or in HOLD, takes effect at the next edge:
  - `cnt`=0, state FILL, running index counter 0.
  - `frame_valid`=0, `frame_data`=0, `frame_index`=0.
  - Fill buffer contents are discarded.
- `s_ready` is 0 while `rst` is high and 1 on the first cycle after reset.
- `s_ready` is a registered-state decode (state==FILL). It has no combinational path from `frame_ready`.
- Latency: `frame_valid` rises on the cycle after the edge that accepts the last sample of the frame, when the output is free.
- Throughput with `frame_ready` tied high: one sample per cycle continuously, one frame every `size` cycles, with no bubbles.
- When a HOLD transfer coincides with frame acceptance, the new frame replaces the old one on the same edge, so `frame_valid` stays high.
- Data and index from the last sample and from the HOLD transfer are visible together on the same edge as `frame_valid`.

## Test plan
- Reset then stream: with `frame_ready`=1, send samples 0x01..0x08 on consecutive cycles -> one cycle after 0x08 is accepted, `frame_valid`=1, `frame_data`=0x0807060504030201, `frame_index`=0.
- Continuous stream: send 0x00..0x17 with `frame_ready`=1 -> three frames with indices 0, 1, 2; `frame_valid` pulses every 8 cycles; `s_ready` never drops.
- Backpressure: hold `frame_ready`=0 and send 16 samples -> frame 0 is held stable, state goes to HOLD, and `s_ready`=0 after the 16th sample. Raise `frame_ready` for one cycle -> frame 1 is presented on the next edge with `frame_valid` still high, and `s_ready` returns to 1 one cycle later.
- Gapped input: toggle `s_valid` randomly with `frame_ready` randomly toggled over 1000 samples -> frames match a scoreboard exactly, with no loss and no duplication.
- Reset mid-operation: assert `rst` after 5 samples, then send 0x11..0x18 -> the first frame is 0x1817161514131211 with `frame_index`=0.
- Index wrap: with `IDX_W`=2, stream 5 frames -> indices are 0, 1, 2, 3, 0.

Source files
------------

// File: rtl/window_frame_packer.sv
// Serial-to-frame packer: gathers `size` 8-bit samples into one frame for the windowing stage.
// A fill buffer plus an output register let the next frame fill while the current one waits.
module window_frame_packer #(
    parameter int size  = 8,
    parameter int IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [size*8-1:0]    frame_data,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic [IDX_W-1:0]     frame_index
);
    // state | meaning
    // FILL  | accepting samples into the fill buffer
    // HOLD  | fill buffer complete, output register still occupied
    localparam int CNT_W = $clog2(size);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(size - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [size*8-1:0]  fill_buf, fill_next;
    logic [IDX_W-1:0]   idx_cnt;
    logic               out_free;
    logic               accept;
    logic               load;

    // Registered-state decode only; reset masks it so no sample is taken mid-reset.
    assign s_ready  = (state == FILL) && !rst;
    assign out_free = !frame_valid || frame_ready;
    assign accept   = s_valid && s_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fill_next  = fill_buf;
        load       = 1'b0;
        for (int j = 0; j < size; j++) begin
            if (accept && cnt == CNT_W'(j)) begin
                fill_next[j*8 +: 8] = s_data;
            end
        end
        case (state)
            FILL: begin
                if (accept) begin
                    if (cnt != LAST) begin
                        cnt_next = cnt + 1'b1;
                    end else if (out_free) begin
                        load     = 1'b1;
                        cnt_next = '0;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            cnt         <= '0;
            fill_buf    <= '0;
            idx_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_index <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            fill_buf <= fill_next;
            // A transfer on the same edge as acceptance replaces the frame, keeping valid high.
            if (load) begin
                frame_valid <= 1'b1;
                frame_data  <= fill_next;
                frame_index <= idx_cnt;
                idx_cnt     <= idx_cnt + 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end
endmodule
